// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer: read-side sequencer for the simple dual-port block RAM.
// A start command walks `length` consecutive addresses from `base_addr`, and
// each word is delivered through a small credit-checked FIFO as a
// valid/ready stream.
// Build option: define RAM_RD_OUTREG_EN when the RAM output register is used.
// That sets the RAM read latency to 2 instead of 1. Any RAM output-register
// enable is tied high outside this block in both builds.
module ram_rd_streamer #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 2
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

`ifdef RAM_RD_OUTREG_EN
    localparam int RL = 2;
`else
    localparam int RL = 1;
`endif
    // One stage for the registered address plus RL stages inside the RAM.
    localparam int PIPE_D = RL + 1;
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int CW     = FIFO_AW + 2;
    localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of words currently travelling through the read pipe.
    function automatic logic [CW-1:0] count_ones(input logic [PIPE_D-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < PIPE_D; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_ptr_r;
    logic [ADDR_W-1:0]   ram_rd_addr_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     issued_r;
    logic [PIPE_D-1:0]   pipe_r;
    logic [PIPE_D-1:0]   pipe_next_s;
    logic [DATA_W-1:0]   fifo_mem_r [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_r;
    logic [FIFO_AW-1:0]  rd_ptr_r;
    logic [FIFO_AW-1:0]  rd_ptr_next_s;
    logic [FIFO_AW:0]    fifo_cnt_r;
    logic [FIFO_AW:0]    fifo_keep_s;
    logic [FIFO_AW:0]    fifo_cnt_next_s;
    logic                busy_r;
    logic                done_r;
    logic                m_valid_r;
    logic [DATA_W-1:0]   m_data_r;
    logic [DATA_W-1:0]   head_next_s;
    logic                push_s;
    logic                pop_s;
    logic                issue_s;
    logic                credit_ok_s;
    logic                last_issue_s;
    logic                drained_s;
    logic [CW-1:0]       occupancy_s;

    // Credit, issue and FIFO next-state decisions for the current cycle.
    always_comb begin
        push_s      = pipe_r[PIPE_D-1];
        pop_s       = m_valid_r & m_ready;
        occupancy_s = CW'(fifo_cnt_r) + count_ones(pipe_r);
        // A word leaving downstream this edge frees its slot immediately.
        if (pop_s) begin
            credit_ok_s = (occupancy_s <= DEPTH_V);
        end else begin
            credit_ok_s = (occupancy_s < DEPTH_V);
        end
        issue_s         = (state_r == RUN) && (issued_r != len_r) && credit_ok_s;
        last_issue_s    = issue_s && ((issued_r + (ADDR_W+1)'(1)) == len_r);
        pipe_next_s     = {pipe_r[PIPE_D-2:0], issue_s};
        fifo_keep_s     = fifo_cnt_r - (FIFO_AW+1)'(pop_s);
        fifo_cnt_next_s = fifo_keep_s + (FIFO_AW+1)'(push_s);
        rd_ptr_next_s   = rd_ptr_r + FIFO_AW'(pop_s);
        // An empty FIFO receiving a word presents that word directly.
        if (push_s && (fifo_keep_s == (FIFO_AW+1)'(0))) begin
            head_next_s = ram_rd_data;
        end else begin
            head_next_s = fifo_mem_r[rd_ptr_next_s];
        end
        drained_s = (fifo_cnt_next_s == (FIFO_AW+1)'(0)) && (pipe_next_s == {PIPE_D{1'b0}});
    end

    // Command FSM, address walk, in-flight pipe and status outputs.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_r       <= IDLE;
            addr_ptr_r    <= {ADDR_W{1'b0}};
            ram_rd_addr_r <= {ADDR_W{1'b0}};
            len_r         <= {(ADDR_W+1){1'b0}};
            issued_r      <= {(ADDR_W+1){1'b0}};
            pipe_r        <= {PIPE_D{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            pipe_r <= pipe_next_s;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        addr_ptr_r <= base_addr;
                        len_r      <= length;
                        issued_r   <= {(ADDR_W+1){1'b0}};
                        if (length == {(ADDR_W+1){1'b0}}) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_s) begin
                        ram_rd_addr_r <= addr_ptr_r;
                        addr_ptr_r    <= addr_ptr_r + ADDR_W'(1);
                        issued_r      <= issued_r + (ADDR_W+1)'(1);
                    end
                    if (last_issue_s || (issued_r == len_r)) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO storage plus the registered stream head.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r   <= {FIFO_AW{1'b0}};
            rd_ptr_r   <= {FIFO_AW{1'b0}};
            fifo_cnt_r <= {(FIFO_AW+1){1'b0}};
            m_valid_r  <= 1'b0;
            m_data_r   <= {DATA_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= ram_rd_data;
                wr_ptr_r             <= wr_ptr_r + FIFO_AW'(1);
            end
            rd_ptr_r   <= rd_ptr_next_s;
            fifo_cnt_r <= fifo_cnt_next_s;
            m_valid_r  <= (fifo_cnt_next_s != (FIFO_AW+1)'(0));
            if (fifo_cnt_next_s != (FIFO_AW+1)'(0)) begin
                m_data_r <= head_next_s;
            end else begin
                m_data_r <= m_data_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign ram_rd_addr = ram_rd_addr_r;
    assign m_data      = m_data_r;
    assign m_valid     = m_valid_r;

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Self-checking bench for ram_rd_streamer: directed and randomized commands
// against a queue-based reference of the expected address walk and data order.
module tb_ram_rd_streamer;

`ifdef RAM_RD_OUTREG_EN
    localparam int RL_TB = 2;
`else
    localparam int RL_TB = 1;
`endif

    logic        rd_clk;
    logic        rd_rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [9:0]  ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;

    logic [7:0]  mem [0:1023];
    logic [7:0]  exp_q [$];
    logic [9:0]  addr_q [$];
    logic [9:0]  last_addr;
    int          vectors;
    int          miscompares;
    int          done_cnt;

    ram_rd_streamer dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Synchronous block-RAM read port model.
`ifdef RAM_RD_OUTREG_EN
    logic [7:0] ram_q;
    always @(posedge rd_clk) begin
        ram_q       <= mem[ram_rd_addr];
        ram_rd_data <= ram_q;
    end
`else
    always @(posedge rd_clk) begin
        ram_rd_data <= mem[ram_rd_addr];
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; check any transfer, hold behaviour and address change.
    task automatic cycle();
        logic       xfer;
        logic       stall;
        logic [7:0] d;
        xfer  = m_valid & m_ready;
        stall = m_valid & ~m_ready;
        d     = m_data;
        @(posedge rd_clk);
        #1;
        if (xfer) begin
            if (exp_q.size() == 0) chk("unexpected_word", 32'(xfer), 32'd0);
            else chk("m_data", 32'(d), 32'(exp_q.pop_front()));
        end
        if (stall) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(d));
        end
        if (ram_rd_addr !== last_addr) begin
            if (addr_q.size() == 0) chk("spurious_addr", 32'(ram_rd_addr), 32'(last_addr));
            else chk("rd_addr", 32'(ram_rd_addr), 32'(addr_q.pop_front()));
            last_addr = ram_rd_addr;
        end
        if (done) done_cnt++;
    endtask

    // Issue one command and follow it to completion.
    task automatic run_cmd(input logic [9:0] b, input logic [10:0] n, input bit rnd_ready,
                           input int poke_at, input int exp_first, input int exp_done);
        int         rel;
        int         first_v;
        int         done_rel;
        int         done_before;
        logic [9:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = b + i[9:0];
            addr_q.push_back(a);
            exp_q.push_back(mem[a]);
        end
        done_before = done_cnt;
        first_v     = -1;
        done_rel    = -1;
        rel         = -1;
        start       = 1'b1;
        base_addr   = b;
        length      = n;
        m_ready     = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (done_rel < 0 && rel < 400) begin
            cycle();
            rel++;
            if (rel == 0) chk("busy_after_start", 32'(busy), 32'(n != 11'd0));
            if (m_valid && first_v < 0) first_v = rel;
            if (done) done_rel = rel;
            if (rel == poke_at) begin
                start     = 1'b1;
                base_addr = b ^ 10'h155;
                length    = 11'd3;
            end else begin
                start = 1'b0;
            end
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        chk("done_seen", 32'(done_rel >= 0), 32'd1);
        chk("first_valid_cycle", 32'(first_v), 32'(exp_first));
        if (exp_done >= 0) chk("done_cycle", 32'(done_rel), 32'(exp_done));
        chk("words_left", 32'(exp_q.size()), 32'd0);
        chk("addrs_left", 32'(addr_q.size()), 32'd0);
        m_ready = 1'b1;
        cycle();
        chk("done_width", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_count", 32'(done_cnt - done_before), 32'd1);
        repeat (3) cycle();
        chk("idle_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        int         saved_done;
        logic [9:0] rb;
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        last_addr   = 10'd0;
        start       = 1'b0;
        base_addr   = 10'd0;
        length      = 11'd0;
        m_ready     = 1'b1;
        for (int a = 0; a < 1024; a++) mem[a] = a[7:0];

        // Reset state.
        rd_rst = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        rd_rst = 1'b0;
        @(posedge rd_clk);
        #1;

        // Basic walk with full-rate downstream and exact latency.
        run_cmd(10'h010, 11'd4, 1'b0, -1, 2 + RL_TB, 6 + RL_TB);
        // Address wrap at the top of the space.
        run_cmd(10'h3FE, 11'd4, 1'b0, -1, 2 + RL_TB, 6 + RL_TB);
        // Zero-length command: done one cycle after start, no data, no address.
        run_cmd(10'h2AA, 11'd0, 1'b0, -1, -1, 0);

        // Abort in the middle of a run under backpressure.
        start     = 1'b1;
        base_addr = 10'h123;
        length    = 11'd16;
        m_ready   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_push(10'h123 + i[9:0]);
        end
        saved_done = done_cnt;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        rd_rst = 1'b1;
        #1;
        chk("abort_addr", 32'(ram_rd_addr), 32'd0);
        chk("abort_valid", 32'(m_valid), 32'd0);
        chk("abort_data", 32'(m_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge rd_clk);
        #1;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_edge_valid", 32'(m_valid), 32'd0);
        rd_rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        last_addr = 10'd0;
        m_ready   = 1'b1;
        repeat (2) cycle();
        chk("no_done_on_abort", 32'(done_cnt - saved_done), 32'd0);
        run_cmd(10'h010, 11'd4, 1'b0, -1, 2 + RL_TB, 6 + RL_TB);

        // Random RAM contents, random backpressure, start poked while busy.
        for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
        rb = 10'($urandom);
        if (rb == last_addr) rb = rb + 10'd1;
        run_cmd(rb, 11'd16, 1'b1, 2, 2 + RL_TB, -1);
        rb = 10'($urandom_range(1000, 1023));
        if (rb == last_addr) rb = rb + 10'd1;
        run_cmd(rb, 11'd16, 1'b1, -1, 2 + RL_TB, -1);
        rb = 10'($urandom);
        if (rb == last_addr) rb = rb + 10'd1;
        run_cmd(rb, 11'($urandom_range(1, 40)), 1'b1, -1, 2 + RL_TB, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Expected data/address for the aborted command (discarded on reset).
    task automatic a_push(input logic [9:0] a);
        addr_q.push_back(a);
        exp_q.push_back(mem[a]);
    endtask

endmodule
